// File: rtl/spi_master_16.sv
// ---------------------------------------------------------------------------
// spi_master_16
//
// Single-word 16-bit SPI master. The host loads a word on dat_i and pulses
// start_i. The block then drives cs_o/sck_o/mosi_o and captures miso_i.
// When the word is finished it returns the received word on dat_o together
// with a one-cycle done_o pulse. It supports all four CPOL/CPHA modes,
// MSB- or LSB-first order and a programmable SCK half-period P (P >= 2).
//
// Frame:  IDLE -> LEAD (P) -> XFER (32 edges, one every P) -> TRAIL (P)
//         -> GAP (P, cs_o high) -> IDLE (done_o)
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      transfer request, sampled every cycle
//   dat_i        word to transmit, captured on an accepted start
//   prescaler_i  SCK half-period P in clk_i cycles
//   conf_cpol    SCK idle level
//   conf_cpha    0: sample on leading edge, 1: sample on trailing edge
//   conf_dir     0: MSB first, 1: LSB first
//   dat_o        last received word, held between transfers
//   done_o       one-cycle completion pulse
//   busy_o       high from accepted start until done_o
//   err_o        sticky errors: [0] start while busy, [1] start with P < 2
//   sck_o, mosi_o, cs_o (active-low)  SPI outputs
//   miso_i       SPI input, already synchronous to the SCK timing
// ---------------------------------------------------------------------------
module spi_master_16 #(
   parameter int PRESC_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [15:0]        dat_i,
   input  logic [PRESC_W-1:0] prescaler_i,
   input  logic               conf_cpol,
   input  logic               conf_cpha,
   input  logic               conf_dir,
   output logic [15:0]        dat_o,
   output logic               done_o,
   output logic               busy_o,
   output logic [1:0]         err_o,
   output logic               sck_o,
   output logic               mosi_o,
   output logic               cs_o,
   input  logic               miso_i
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_XFER  = 3'd2,
      ST_TRAIL = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam logic [PRESC_W-1:0] ONE_P  = {{(PRESC_W-1){1'b0}}, 1'b1};
   localparam logic [PRESC_W-1:0] ZERO_P = {PRESC_W{1'b0}};
   localparam logic [4:0]         LAST_EDGE = 5'd31;

   // Bit that goes onto the wire next for the selected order.
   function automatic logic head_bit(input logic [15:0] w, input logic lsb_first);
      if (lsb_first) begin
         head_bit = w[0];
      end else begin
         head_bit = w[15];
      end
   endfunction

   // Discard the transmitted bit from the TX word.
   function automatic logic [15:0] shift_tx(input logic [15:0] w, input logic lsb_first);
      if (lsb_first) begin
         shift_tx = {1'b0, w[15:1]};
      end else begin
         shift_tx = {w[14:0], 1'b0};
      end
   endfunction

   // Insert a received bit: at bit 0 for MSB first, at bit 15 for LSB first.
   function automatic logic [15:0] shift_rx(input logic [15:0] w, input logic b,
                                            input logic lsb_first);
      if (lsb_first) begin
         shift_rx = {b, w[15:1]};
      end else begin
         shift_rx = {w[14:0], b};
      end
   endfunction

   // State and datapath registers
   state_t             state_r;
   state_t             state_nxt_s;
   logic [PRESC_W-1:0] cnt_r;
   logic [4:0]         edge_cnt_r;
   logic [PRESC_W-1:0] p_r;
   logic               cpol_r;
   logic               cpha_r;
   logic               dir_r;
   logic [15:0]        tx_r;
   logic [15:0]        rx_r;

   // Registered outputs and their next values
   logic               cs_r,   cs_nxt_s;
   logic               sck_r,  sck_nxt_s;
   logic               mosi_r, mosi_nxt_s;
   logic               busy_r, busy_nxt_s;
   logic               done_r, done_nxt_s;
   logic [15:0]        dat_r,  dat_nxt_s;
   logic [1:0]         err_r,  err_nxt_s;
   logic [15:0]        tx_nxt_s;
   logic [15:0]        rx_nxt_s;

   // Decoded conditions
   logic               p_legal_s;
   logic               accept_s;
   logic               cnt_zero_s;
   logic               edge_s;
   logic               shift_out_s;
   logic               sample_s;

   assign p_legal_s  = (prescaler_i > ONE_P);
   assign accept_s   = (state_r == ST_IDLE) && start_i && p_legal_s;
   assign cnt_zero_s = (cnt_r == ZERO_P);

   // An SCK edge is produced at the end of every half-period in LEAD and XFER;
   // the LEAD exit produces edge 0, so edge k lands at 1+P+kP.
   assign edge_s = ((state_r == ST_LEAD) || (state_r == ST_XFER)) && cnt_zero_s;

   // Even edge index = leading edge, odd = trailing edge. With CPHA=0 the
   // first bit is already out from LEAD entry, so no new bit after edge 31.
   assign shift_out_s = edge_s && (cpha_r ? ~edge_cnt_r[0]
                                          : (edge_cnt_r[0] && (edge_cnt_r != LAST_EDGE)));
   assign sample_s    = edge_s && (cpha_r ? edge_cnt_r[0] : ~edge_cnt_r[0]);

   assign cs_o   = cs_r;
   assign sck_o  = sck_r;
   assign mosi_o = mosi_r;
   assign busy_o = busy_r;
   assign done_o = done_r;
   assign dat_o  = dat_r;
   assign err_o  = err_r;

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_LEAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LEAD: begin
            if (cnt_zero_s) begin
               state_nxt_s = ST_XFER;
            end else begin
               state_nxt_s = ST_LEAD;
            end
         end
         ST_XFER: begin
            if (cnt_zero_s && (edge_cnt_r == LAST_EDGE)) begin
               state_nxt_s = ST_TRAIL;
            end else begin
               state_nxt_s = ST_XFER;
            end
         end
         ST_TRAIL: begin
            if (cnt_zero_s) begin
               state_nxt_s = ST_GAP;
            end else begin
               state_nxt_s = ST_TRAIL;
            end
         end
         ST_GAP: begin
            if (cnt_zero_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_GAP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM output logic: next values of the registered outputs and shifters
   always_comb begin
      cs_nxt_s   = 1'b1;
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      sck_nxt_s  = sck_r;
      mosi_nxt_s = mosi_r;
      tx_nxt_s   = tx_r;
      rx_nxt_s   = rx_r;
      dat_nxt_s  = dat_r;
      err_nxt_s  = err_r;

      case (state_nxt_s)
         ST_LEAD, ST_XFER, ST_TRAIL: begin
            cs_nxt_s   = 1'b0;
            busy_nxt_s = 1'b1;
         end
         ST_GAP: begin
            cs_nxt_s   = 1'b1;
            busy_nxt_s = 1'b1;
         end
         default: begin
            cs_nxt_s   = 1'b1;
            busy_nxt_s = 1'b0;
         end
      endcase

      // SCK follows the live CPOL whenever idle; the 32 toggles of a
      // transfer bring it back to the latched CPOL.
      if ((state_r == ST_IDLE) || (state_nxt_s == ST_IDLE)) begin
         sck_nxt_s = conf_cpol;
      end else if (edge_s) begin
         sck_nxt_s = ~sck_r;
      end else begin
         sck_nxt_s = sck_r;
      end

      if (state_r == ST_IDLE) begin
         if (accept_s && !conf_cpha) begin
            mosi_nxt_s = head_bit(dat_i, conf_dir);
            tx_nxt_s   = shift_tx(dat_i, conf_dir);
         end else if (accept_s) begin
            mosi_nxt_s = 1'b1;
            tx_nxt_s   = dat_i;
         end else begin
            mosi_nxt_s = 1'b1;
            tx_nxt_s   = tx_r;
         end
      end else if (shift_out_s) begin
         mosi_nxt_s = head_bit(tx_r, dir_r);
         tx_nxt_s   = shift_tx(tx_r, dir_r);
      end else if ((state_r == ST_TRAIL) && cnt_zero_s) begin
         mosi_nxt_s = 1'b1;
         tx_nxt_s   = tx_r;
      end else begin
         mosi_nxt_s = mosi_r;
         tx_nxt_s   = tx_r;
      end

      if (accept_s) begin
         rx_nxt_s = 16'h0000;
      end else if (sample_s) begin
         rx_nxt_s = shift_rx(rx_r, miso_i, dir_r);
      end else begin
         rx_nxt_s = rx_r;
      end

      if ((state_r == ST_GAP) && cnt_zero_s) begin
         done_nxt_s = 1'b1;
         dat_nxt_s  = rx_r;
      end else begin
         done_nxt_s = 1'b0;
         dat_nxt_s  = dat_r;
      end

      // A start in IDLE that is not accepted can only be an illegal P.
      if (accept_s) begin
         err_nxt_s = 2'b00;
      end else if (start_i && (state_r == ST_IDLE)) begin
         err_nxt_s = err_r | 2'b10;
      end else if (start_i) begin
         err_nxt_s = err_r | 2'b01;
      end else begin
         err_nxt_s = err_r;
      end
   end

   // Output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cs_r   <= 1'b1;
         sck_r  <= 1'b0;
         mosi_r <= 1'b1;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dat_r  <= 16'h0000;
         err_r  <= 2'b00;
      end else begin
         cs_r   <= cs_nxt_s;
         sck_r  <= sck_nxt_s;
         mosi_r <= mosi_nxt_s;
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
         dat_r  <= dat_nxt_s;
         err_r  <= err_nxt_s;
      end
   end

   // Half-period / edge counters, configuration latch and shift registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_r      <= ZERO_P;
         edge_cnt_r <= 5'd0;
         p_r        <= ZERO_P;
         cpol_r     <= 1'b0;
         cpha_r     <= 1'b0;
         dir_r      <= 1'b0;
         tx_r       <= 16'h0000;
         rx_r       <= 16'h0000;
      end else begin
         tx_r <= tx_nxt_s;
         rx_r <= rx_nxt_s;
         if (accept_s) begin
            cnt_r      <= prescaler_i - ONE_P;
            edge_cnt_r <= 5'd0;
            p_r        <= prescaler_i;
            cpol_r     <= conf_cpol;
            cpha_r     <= conf_cpha;
            dir_r      <= conf_dir;
         end else if (state_r != ST_IDLE) begin
            if (cnt_zero_s) begin
               cnt_r <= p_r - ONE_P;
            end else begin
               cnt_r <= cnt_r - ONE_P;
            end
            // Holds at 31 once the final edge has been produced.
            if (edge_s && (edge_cnt_r != LAST_EDGE)) begin
               edge_cnt_r <= edge_cnt_r + 5'd1;
            end else begin
               edge_cnt_r <= edge_cnt_r;
            end
         end else begin
            cnt_r      <= cnt_r;
            edge_cnt_r <= edge_cnt_r;
         end
      end
   end

   // cpol_r is latched for completeness of the configuration snapshot; the
   // SCK level itself is carried by sck_r through the transfer.
   logic unused_cpol_s;
   assign unused_cpol_s = cpol_r;

endmodule

// File: doc/spi_master_16.md
# spi_master_16

Single-word 16-bit SPI master, the initiating end of the link served by the team's SPI slave. Host logic loads a word, pulses `start_i`, and the block drives `cs_o`/`sck_o`/`mosi_o` while capturing `miso_i`. It returns the received word with a one-cycle `done_o`. It supports all four CPOL/CPHA modes, MSB- or LSB-first order, and a programmable SCK half-period.

## Interface
- `PRESC_W`, default 8: width of the half-period prescaler input.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  transfer request, sampled each cycle.
- `dat_i`  in  16  word to transmit, captured on an accepted start.
- `prescaler_i`  in  PRESC_W  SCK half-period P in `clk_i` cycles. Legal range is P ≥ 2.
- `conf_cpol`  in  1  SCK idle level.
- `conf_cpha`  in  1  0: sample on leading edge. 1: sample on trailing edge.
- `conf_dir`  in  1  0: MSB first. 1: LSB first.
- `dat_o`  out  16  last received word. Holds its value between transfers.
- `done_o`  out  1  one-cycle pulse when a transfer completes.
- `busy_o`  out  1  high from accepted start until `done_o`.
- `err_o`  out  2  [0] start while busy. [1] start with P < 2. Sticky; both bits clear on the next accepted start.
- `sck_o`, `mosi_o`, `cs_o`  out  1  PHY outputs. `cs_o` is active-low.
- `miso_i`  in  1  PHY input. Already synchronous to SCK timing; no synchronizer.

## Operation
- Reset values:
  - `cs_o`=1, `sck_o`=0, `mosi_o`=1, `busy_o`=0, `done_o`=0.
  - `dat_o`=0, `err_o`=0.
  - State is IDLE.
- IDLE:
  - `sck_o` is registered from `conf_cpol` every cycle.
  - `cs_o`=1, `mosi_o`=1.
- Accepted start:
  - Condition: `start_i`=1 in IDLE with P ≥ 2.
  - Latches `dat_i`, P, `conf_cpol`, `conf_cpha` and `conf_dir`. Config changes during a transfer have no effect.
  - Next state is LEAD.
- Rejected starts:
  - `start_i` with P < 2 in IDLE sets `err_o[1]` and the block stays in IDLE.
  - `start_i` while not in IDLE sets `err_o[0]` and the transfer continues undisturbed.
- States: IDLE → LEAD → XFER → TRAIL → GAP → IDLE.
  - LEAD: `cs_o`=0 for P cycles. If CPHA=0, `mosi_o` presents the first bit from LEAD entry.
  - XFER: 32 SCK edges, one every P cycles; edge counter k runs 0..31. Even k is a leading edge, odd k is a trailing edge. `sck_o` returns to CPOL after edge 31.
  - TRAIL: `cs_o` stays 0 for P cycles.
  - GAP: `cs_o`=1 for P cycles. This keeps the slave's 2-flop CS detector valid between back-to-back words.
- CPHA=0:
  - `miso_i` is sampled on the clock cycle where a leading edge is driven.
  - The next bit goes to `mosi_o` on each trailing edge, except after the last trailing edge.
- CPHA=1:
  - The next bit goes to `mosi_o` on each leading edge.
  - `miso_i` is sampled on each trailing edge.
- Bit order and shifting:
  - MSB first: the TX word shifts left and RX shifts left, inserting at bit 0.
  - LSB first: the TX word shifts right and RX shifts right, inserting at bit 15.
- Completion: on the GAP→IDLE cycle, `dat_o` is loaded with the RX register, `done_o`=1 for one cycle, and `busy_o` falls.
- Counters:
  - The half-period counter is PRESC_W bits, loads P−1 and counts down to 0.
  - The edge counter is 5 bits and performs no wrap beyond 31.
- Reset mid-transfer: all outputs return to their reset values immediately (asynchronously). The RX data in flight is discarded and `dat_o` returns to 0.

## Timing
- Start sampled at cycle 0: `busy_o`=1 and `cs_o`=0 at cycle 1.
- Edge k toggles `sck_o` at cycle 1+P+kP.
- Edge 31 occurs at cycle 1+32P.
- `cs_o` rises at cycle 1+33P.
- `done_o`, `dat_o` valid and `busy_o`=0 at cycle 1+34P.
- A start is accepted in the same cycle `busy_o` falls: `done_o` and the new start may coincide. A `start_i` during the `done_o` cycle is accepted with no error.
- SCK frequency = f_clk/(2P). For P=2, one word takes 69 cycles.

## Test plan
- Mode 0, MSB first, P=2, `miso_i` looped to `mosi_o`, `dat_i`=16'hA5C3:
  - `dat_o`=16'hA5C3 at cycle 69.
  - Exactly 16 rising `sck_o` edges.
  - `cs_o` low for cycles 1..66.
- All four CPOL/CPHA modes against a behavioral slave returning 16'h1234, with `dat_i`=16'hBEEF:
  - Master `dat_o`=16'h1234 and slave receives 16'hBEEF.
  - `sck_o` idle level equals CPOL before and after the transfer.
- LSB first, loopback, `dat_i`=16'h0001: the first `mosi_o` bit is 1 and `dat_o`=16'h0001. Repeat with MSB first and `dat_i`=16'h8000.
- Error paths:
  - `start_i` with P=1: `err_o`=2'b10, no `cs_o` activity.
  - Second `start_i` mid-transfer: `err_o[0]`=1 and the first word still completes correctly.
  - The next valid start clears `err_o`.
- Back-to-back starts on the `done_o` cycle, P=3: the `cs_o` high gap is ≥3 cycles and both words are received intact.
- Assert `rst_i` at cycle 20 of a P=2 transfer: `cs_o`=1, `sck_o`=0, `busy_o`=0 immediately, and no `done_o` pulse follows.
